match_clock_ctrl: RTL and testbench
===================================

Name: match_clock_ctrl

Overview:
- Parametrised game-timing controller for the game server.
- Generates the physics/step frame tick, runs the match countdown in whole seconds, and handles start/pause/restart.
- Adds bonus-time injection, a match-over pulse and BCD time digits for the seven-segment driver.
- Sits between the debounced/one-pulsed buttons and the step, VGA and seven-segment blocks.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- FRAME_HZ, 120, frame tick rate in Hz. FRAME_DIV = CLK_HZ/FRAME_HZ, integer, must be >= 2.
- MATCH_SEC, 180, match length in seconds loaded on reset/restart. Must satisfy 1 <= MATCH_SEC <= 2^SEC_W-1.
- SEC_W, 8, width of the seconds counter. Must be <= 9 so the value fits in 3 BCD digits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-high (asserted = 1 resets on the next posedge clk).
- start_p  in  1  one-cycle start/pause toggle pulse.
- restart_p  in  1  one-cycle restart pulse.
- add_valid  in  1  bonus-time request.
- add_sec  in  SEC_W  bonus seconds to add.
- frame_tick  out  1  one-cycle pulse per frame, only while RUN.
- sec_tick  out  1  one-cycle pulse when a second elapses in RUN.
- time_left  out  SEC_W  seconds remaining.
- bcd_h, bcd_t, bcd_o  out  4 each  hundreds/tens/ones digits of time_left.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
- match_over  out  1  one-cycle pulse on entering OVER.

Behaviour:
- Reset: state=IDLE, time_left=MATCH_SEC, frame and second dividers=0, all pulses 0.
- Frame divider:
  - Counts 0..FRAME_DIV-1, advancing only in RUN and holding in IDLE/PAUSE/OVER.
  - frame_tick=1 in the cycle the count equals FRAME_DIV-1 while in RUN; count then wraps to 0.
- Second divider:
  - Counts 0..CLK_HZ-1 with the same RUN-only advance and hold rule.
  - At CLK_HZ-1: sec_tick=1 for one cycle and time_left decrements by 1.
  - Pausing mid-second resumes from the held count; no time is lost or gained.
- FSM transitions on start_p:
  - IDLE -> RUN.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
  - OVER: ignored.
- restart_p from any state -> IDLE, time_left=MATCH_SEC, dividers cleared.
  - restart_p has priority over start_p in the same cycle.
- End of match: a decrement that makes time_left 0 moves the FSM to OVER on the same edge.
  - match_over=1 for exactly that one cycle.
  - frame_tick and sec_tick stay 0 in OVER.
- Bonus time:
  - Honoured in IDLE, RUN and PAUSE; ignored in OVER.
  - new = time_left - dec + add_sec, where dec = sec_tick condition. Computed at SEC_W+1 bits and saturated to 2^SEC_W-1.
  - If dec and add occur together and the net result is > 0, no OVER transition.
- BCD outputs: combinational from the registered time_left; zero added latency.
- Outputs state, time_left, frame_tick, sec_tick and match_over are registered.
- Reset and restart mid-second or mid-frame discard partial counts.

Optional Feature:
- Macro MATCH_CLOCK_WARN_EN adds output warn (1 bit).
- With the macro: warn=1 while state is RUN or PAUSE and 0 < time_left <= 10; warn=0 otherwise and on reset.
- Without the macro: the port and its logic are absent.

Test Plan:
- Parameters CLK_HZ=100, FRAME_HZ=10, MATCH_SEC=3: reset, start_p -> state=01; frame_tick every 10 cycles; sec_tick after 100 cycles; time_left 3->2; bcd_o=2.
- Run 300 cycles from start -> time_left=0, state=11, match_over high exactly 1 cycle; further start_p leaves state=11.
- Pause at divider count 40 for 500 cycles, then resume -> next sec_tick 60 cycles after resume; no frame_tick while paused.
- add_valid with add_sec=250 at time_left=3 (SEC_W=8) -> time_left=253; add_sec=5 at 253 -> saturates to 255. add_sec=1 in the same cycle as the decrement that would reach 0 -> time_left=1, no OVER.
- restart_p asserted together with start_p in RUN -> state=00, time_left=3, dividers 0; rst_n=1 mid-run gives the same result.
- With MATCH_CLOCK_WARN_EN and MATCH_SEC=12: warn=0 at 12 and 11, becomes 1 at 10, 0 in OVER.

Source files
------------

// File: rtl/match_clock_ctrl.sv
// Match timing controller: frame tick, whole-second countdown, start/pause/restart, bonus time, BCD digits.
// Optional `MATCH_CLOCK_WARN_EN adds a registered low-time warning output.
module match_clock_ctrl #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned FRAME_HZ  = 120,
  parameter int unsigned MATCH_SEC = 180,
  parameter int unsigned SEC_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic             restart_p,
  input  logic             add_valid,
  input  logic [SEC_W-1:0] add_sec,
  output logic             frame_tick,
  output logic             sec_tick,
  output logic [SEC_W-1:0] time_left,
  output logic [3:0]       bcd_h,
  output logic [3:0]       bcd_t,
  output logic [3:0]       bcd_o,
  output logic [1:0]       state,
  output logic             match_over
`ifdef MATCH_CLOCK_WARN_EN
  ,
  output logic             warn
`endif
);

  localparam int unsigned FRAME_DIV = CLK_HZ / FRAME_HZ;
  localparam int unsigned FCW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned SCW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TW        = SEC_W + 1;
  localparam logic [FCW-1:0]   FRAME_LAST = FCW'(FRAME_DIV - 1);
  localparam logic [SCW-1:0]   SEC_LAST   = SCW'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] TIME_INIT  = SEC_W'(MATCH_SEC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SCW-1:0]   sec_cnt_q, sec_cnt_d;
  logic [SEC_W-1:0] time_q, time_d;
  logic             frame_tick_q, frame_tick_d;
  logic             sec_tick_q, sec_tick_d;
  logic             match_over_q, match_over_d;
  logic             adv, frame_wrap, sec_wrap, add_en, over_entry;
  logic [TW-1:0]    sum;
`ifdef MATCH_CLOCK_WARN_EN
  logic             warn_q, warn_d;
`endif

  // Dividers advance only on RUN cycles that are not being paused or restarted,
  // so a pause freezes the partial second exactly where it was.
  always_comb begin
    adv        = (state_q == S_RUN) && !start_p && !restart_p;
    frame_wrap = adv && (frame_cnt_q == FRAME_LAST);
    sec_wrap   = adv && (sec_cnt_q == SEC_LAST);

    frame_cnt_d = frame_cnt_q;
    if (adv) frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + FCW'(1);
    sec_cnt_d = sec_cnt_q;
    if (adv) sec_cnt_d = sec_wrap ? '0 : sec_cnt_q + SCW'(1);

    add_en = add_valid && (state_q != S_OVER);
    sum    = {1'b0, time_q} - TW'(sec_wrap) + (add_en ? TW'(add_sec) : TW'(0));
    time_d = sum[SEC_W] ? '1 : sum[SEC_W-1:0];
    over_entry = sec_wrap && (time_d == '0);

    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_p) state_d = S_RUN;
      S_RUN:   begin
        if (over_entry)   state_d = S_OVER;
        else if (start_p) state_d = S_PAUSE;
      end
      S_PAUSE: if (start_p) state_d = S_RUN;
      default: state_d = state_q;
    endcase

    // The final decrement is reported by match_over alone; ticks never show in OVER.
    frame_tick_d = frame_wrap && !over_entry;
    sec_tick_d   = sec_wrap && !over_entry;
    match_over_d = over_entry;
`ifdef MATCH_CLOCK_WARN_EN
    warn_d = ((state_d == S_RUN) || (state_d == S_PAUSE)) &&
             (time_d != '0) && (32'(time_d) <= 32'd10);
`endif
  end

  // Reset and restart share one path: IDLE, full time, dividers and pulses cleared.
  always_ff @(posedge clk) begin
    if (rst_n || restart_p) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= '0;
      sec_cnt_q    <= '0;
      time_q       <= TIME_INIT;
      frame_tick_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      match_over_q <= 1'b0;
`ifdef MATCH_CLOCK_WARN_EN
      warn_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      sec_cnt_q    <= sec_cnt_d;
      time_q       <= time_d;
      frame_tick_q <= frame_tick_d;
      sec_tick_q   <= sec_tick_d;
      match_over_q <= match_over_d;
`ifdef MATCH_CLOCK_WARN_EN
      warn_q       <= warn_d;
`endif
    end
  end

  // BCD digits straight from the registered count; SEC_W <= 9 keeps it below 512.
  logic [9:0] tv;
  always_comb begin
    tv    = 10'(time_q);
    bcd_h = 4'(tv / 10'd100);
    bcd_t = 4'((tv % 10'd100) / 10'd10);
    bcd_o = 4'(tv % 10'd10);
  end

  assign state      = state_q;
  assign time_left  = time_q;
  assign frame_tick = frame_tick_q;
  assign sec_tick   = sec_tick_q;
  assign match_over = match_over_q;
`ifdef MATCH_CLOCK_WARN_EN
  assign warn       = warn_q;
`endif

endmodule

// File: tb/tb_match_clock_ctrl.sv
// Scoreboard bench for match_clock_ctrl with CLK_HZ=100, FRAME_HZ=10, MATCH_SEC=3, SEC_W=8.
module tb_match_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start_p, restart_p, add_valid;
  logic [7:0] add_sec;
  logic       frame_tick, sec_tick, match_over;
  logic [7:0] time_left;
  logic [3:0] bcd_h, bcd_t, bcd_o;
  logic [1:0] state;
`ifdef MATCH_CLOCK_WARN_EN
  logic       warn;
`endif

  match_clock_ctrl #(.CLK_HZ(100), .FRAME_HZ(10), .MATCH_SEC(3), .SEC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_p(start_p), .restart_p(restart_p),
    .add_valid(add_valid), .add_sec(add_sec), .frame_tick(frame_tick),
    .sec_tick(sec_tick), .time_left(time_left), .bcd_h(bcd_h), .bcd_t(bcd_t),
    .bcd_o(bcd_o), .state(state), .match_over(match_over)
`ifdef MATCH_CLOCK_WARN_EN
    , .warn(warn)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       sec;
    logic       mo;
    logic [7:0] tl;
    logic [1:0] st;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   frame_n = 0;
  int   last_frame = -1;
  int   mo_n = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every sec_tick or match_over is matched against the next queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (frame_tick) begin
      frame_n++;
      last_frame = cyc;
    end
    if (match_over) mo_n++;
    if (sec_tick || match_over) begin
      if (sbq.size() == 0) check("unexpected_event", cyc, -1);
      else begin
        x = sbq.pop_front();
        check("ev_cycle", cyc, x.cyc);
        check("ev_sec_tick", sec_tick, x.sec);
        check("ev_match_over", match_over, x.mo);
        check("ev_time_left", time_left, x.tl);
        check("ev_state", state, x.st);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_start(output int e);
    @(negedge clk); start_p = 1'b1;
    @(negedge clk); start_p = 1'b0;
    e = cyc;
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart_p = 1'b1;
    @(negedge clk); restart_p = 1'b0;
  endtask

  task automatic pulse_add(input logic [7:0] v);
    @(negedge clk); add_valid = 1'b1; add_sec = v;
    @(negedge clk); add_valid = 1'b0; add_sec = '0;
  endtask

  task automatic push(input int c, input logic s, input logic m, input logic [7:0] t, input logic [1:0] st);
    exp_t x;
    x.cyc = c; x.sec = s; x.mo = m; x.tl = t; x.st = st;
    sbq.push_back(x);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, p, r, f0, f1;
    rst_n = 1'b1; start_p = 1'b0; restart_p = 1'b0; add_valid = 1'b0; add_sec = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("reset_state", state, 0);
    check("reset_time", time_left, 3);
    check("reset_frame_tick", frame_tick, 0);
    check("reset_sec_tick", sec_tick, 0);
    check("reset_match_over", match_over, 0);
    check("reset_bcd", {bcd_h, bcd_t, bcd_o}, 12'h003);
`ifdef MATCH_CLOCK_WARN_EN
    check("reset_warn", warn, 0);
`endif

    // Full match: ticks at +100/+200, OVER at +300
    f0 = frame_n;
    pulse_start(e); #1;
    check("start_state", state, 1);
    push(e + 100, 1'b1, 1'b0, 8'd2, 2'd1);
    push(e + 200, 1'b1, 1'b0, 8'd1, 2'd1);
    push(e + 300, 1'b0, 1'b1, 8'd0, 2'd3);
`ifdef MATCH_CLOCK_WARN_EN
    check("run_warn", warn, 1);
`endif
    wait_cyc(e + 15); #1;
    check("first_frame_cycle", last_frame, e + 10);
    wait_cyc(e + 101); #1;
    check("bcd_after_first_sec", {bcd_h, bcd_t, bcd_o}, 12'h002);
    check("frames_first_sec", frame_n - f0, 10);
    wait_cyc(e + 302); #1;
    check("over_state", state, 3);
    check("over_time", time_left, 0);
    check("match_over_one_cycle", match_over, 0);
    check("match_over_count", mo_n, 1);
    check("frames_full_match", frame_n - f0, 29);
`ifdef MATCH_CLOCK_WARN_EN
    check("over_warn", warn, 0);
`endif
    pulse_start(e);
    repeat (20) @(negedge clk); #1;
    check("over_ignores_start", state, 3);
    check("no_frames_in_over", frame_n - f0, 29);
    check("match_over_still_once", mo_n, 1);

    // Pause at second-divider count 40, resume: next tick 60 cycles later
    pulse_restart(); #1;
    check("restart_state", state, 0);
    check("restart_time", time_left, 3);
    f0 = frame_n;
    pulse_start(e);
    wait_cyc(e + 39);
    pulse_start(p); #1;
    check("pause_state", state, 2);
    f1 = frame_n;
    check("frames_before_pause", f1 - f0, 4);
    wait_cyc(p + 500); #1;
    check("no_frames_paused", frame_n, f1);
    check("time_held_paused", time_left, 3);
    pulse_start(r);
    push(r + 60, 1'b1, 1'b0, 8'd2, 2'd1);
    wait_cyc(r + 65); #1;
    check("resume_tick_consumed", sbq.size(), 0);

    // Bonus time in IDLE with saturation
    pulse_restart();
    pulse_add(8'd250); #1;
    check("bonus_253", time_left, 253);
    check("bonus_bcd", {bcd_h, bcd_t, bcd_o}, 12'h253);
    pulse_add(8'd5); #1;
    check("bonus_saturate", time_left, 255);
    check("bonus_sat_bcd", {bcd_h, bcd_t, bcd_o}, 12'h255);
    check("bonus_idle_state", state, 0);

    // Bonus coinciding with the would-be final decrement
    pulse_restart();
    pulse_start(e);
    push(e + 100, 1'b1, 1'b0, 8'd2, 2'd1);
    push(e + 200, 1'b1, 1'b0, 8'd1, 2'd1);
    push(e + 300, 1'b1, 1'b0, 8'd1, 2'd1);
    wait_cyc(e + 299);
    add_valid = 1'b1; add_sec = 8'd1;
    @(negedge clk); add_valid = 1'b0; add_sec = '0;
    wait_cyc(e + 305); #1;
    check("bonus_rescue_state", state, 1);
    check("bonus_rescue_time", time_left, 1);
    check("bonus_rescue_no_over", mo_n, 1);
    pulse_restart();

    // restart_p beats start_p in RUN
    pulse_start(e);
    wait_cyc(e + 30);
    @(negedge clk); start_p = 1'b1; restart_p = 1'b1;
    @(negedge clk); start_p = 1'b0; restart_p = 1'b0; #1;
    check("restart_prio_state", state, 0);
    check("restart_prio_time", time_left, 3);
    pulse_start(e);
    push(e + 100, 1'b1, 1'b0, 8'd2, 2'd1);
    wait_cyc(e + 12); #1;
    check("frame_after_restart", last_frame, e + 10);

    // Synchronous reset mid-run
    wait_cyc(e + 150);
    rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b0; #1;
    check("midrun_reset_state", state, 0);
    check("midrun_reset_time", time_left, 3);
    pulse_start(e);
    push(e + 100, 1'b1, 1'b0, 8'd2, 2'd1);
    wait_cyc(e + 105); #1;
    check("divider_cleared_by_reset", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
